// File: rtl/alu_sweep_pkg.sv
// alu_sweep_pkg -- shared definitions for the alu_sweep sequencer.
//
// Holds the sequencer state encodings and the ALU opcode constant.
// The board harness drives the ALU opcode input from ALU_OP_ADD:
// ADD, with both sources taken from word memory.
package alu_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] ALU_OP_ADD = 8'h07;

endpackage

// File: rtl/alu_sweep.sv
// alu_sweep -- element-wise vector add sequencer between ram_word and alu.
//
// This module sweeps len elements: c[c_base+i] = a[a_base+i] + b[b_base+i].
// It is a single flat module. The board harness places it between a
// three-port word memory and a combinational ALU fixed to ADD.
//
// Ports:
//   clk, rst_n        clock; asynchronous active-low reset
//   start             request a sweep (only honoured in IDLE)
//   a_base, b_base    operand base addresses
//   c_base            result base address
//   len               element count, 0..2^AWIDTH
//   alu_out, alu_c_out  ALU sum and carry for the current read addresses
//   port_a_address, port_b_address  memory read addresses
//   port_c_address, port_c_data, port_c_we  memory write port
//   busy              high while in READ or WRITE
//   done              one-cycle pulse when a sweep finishes
//   carry_any         sticky OR of ALU carries in the current sweep
//   carry_cnt         number of carries in the current sweep
//                     (only when ALU_SWEEP_CARRY_CNT_EN is defined)
//   dbg_state         current sequencer state, for observation
//
// Handshake: start is a level request sampled on a rising edge while in
// IDLE. The sweep is accepted on that edge, and the base and len inputs
// are captured on the same edge. done marks the single cycle after the
// last write. No back-pressure exists in either direction.
//
// Configuration macro: ALU_SWEEP_CARRY_CNT_EN adds the carry_cnt port
// and its counter.
module alu_sweep
    import alu_sweep_pkg::*;
#(
    parameter int WIDTH  = 3,
    parameter int AWIDTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AWIDTH-1:0] a_base,
    input  logic [AWIDTH-1:0] b_base,
    input  logic [AWIDTH-1:0] c_base,
    input  logic [AWIDTH:0]   len,
    input  logic [WIDTH-1:0]  alu_out,
    input  logic              alu_c_out,
    output logic [AWIDTH-1:0] port_a_address,
    output logic [AWIDTH-1:0] port_b_address,
    output logic [AWIDTH-1:0] port_c_address,
    output logic [WIDTH-1:0]  port_c_data,
    output logic              port_c_we,
    output logic              busy,
    output logic              done,
    output logic              carry_any,
`ifdef ALU_SWEEP_CARRY_CNT_EN
    output logic [AWIDTH:0]   carry_cnt,
`endif
    output state_t            dbg_state
);

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] a_base_q, a_base_d;
    logic [AWIDTH-1:0] b_base_q, b_base_d;
    logic [AWIDTH-1:0] c_base_q, c_base_d;
    logic [AWIDTH:0]   len_q, len_d;
    logic [AWIDTH:0]   idx_q, idx_d;
    logic              carry_any_q, carry_any_d;
    logic [AWIDTH:0]   idx_next;
`ifdef ALU_SWEEP_CARRY_CNT_EN
    logic [AWIDTH:0]   carry_cnt_q, carry_cnt_d;
`endif

    assign idx_next = idx_q + {{AWIDTH{1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_base_q    <= '0;
            b_base_q    <= '0;
            c_base_q    <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            carry_any_q <= 1'b0;
`ifdef ALU_SWEEP_CARRY_CNT_EN
            carry_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            a_base_q    <= a_base_d;
            b_base_q    <= b_base_d;
            c_base_q    <= c_base_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            carry_any_q <= carry_any_d;
`ifdef ALU_SWEEP_CARRY_CNT_EN
            carry_cnt_q <= carry_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        a_base_d    = a_base_q;
        b_base_d    = b_base_q;
        c_base_d    = c_base_q;
        len_d       = len_q;
        idx_d       = idx_q;
        carry_any_d = carry_any_q;
`ifdef ALU_SWEEP_CARRY_CNT_EN
        carry_cnt_d = carry_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_base_d    = a_base;
                    b_base_d    = b_base;
                    c_base_d    = c_base;
                    len_d       = len;
                    idx_d       = '0;
                    carry_any_d = 1'b0;
`ifdef ALU_SWEEP_CARRY_CNT_EN
                    carry_cnt_d = '0;
`endif
                    state_d     = (len != '0) ? ST_READ : ST_DONE;
                end
            end
            ST_READ: begin
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                carry_any_d = carry_any_q | alu_c_out;
`ifdef ALU_SWEEP_CARRY_CNT_EN
                carry_cnt_d = carry_cnt_q + {{AWIDTH{1'b0}}, alu_c_out};
`endif
                if (idx_next < len_q) begin
                    idx_d   = idx_next;
                    state_d = ST_READ;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Addresses come from registered bases plus the registered index.
    // They do not change between READ and WRITE, so the combinational ALU
    // result is settled by the time the write is enabled. All registers
    // reset to zero, so reset also drives every address to zero.
    assign port_a_address = a_base_q + idx_q[AWIDTH-1:0];
    assign port_b_address = b_base_q + idx_q[AWIDTH-1:0];
    assign port_c_address = c_base_q + idx_q[AWIDTH-1:0];

    // Write data is gated to zero outside WRITE. This keeps the port quiet
    // while idle and makes reset force it low at once.
    assign port_c_we   = (state_q == ST_WRITE);
    assign port_c_data = (state_q == ST_WRITE) ? alu_out : '0;
    assign busy        = (state_q == ST_READ) || (state_q == ST_WRITE);
    assign done        = (state_q == ST_DONE);
    assign carry_any   = carry_any_q;
    assign dbg_state   = state_q;
`ifdef ALU_SWEEP_CARRY_CNT_EN
    assign carry_cnt   = carry_cnt_q;
`endif

endmodule

// File: tb/tb_alu_sweep.sv
// tb_alu_sweep -- directed self-checking bench for alu_sweep.
//
// Models the board harness: a 4x3-bit word memory and an adder ALU,
// with the DUT instantiated between them. Stimulus is a linear
// sequence of directed steps. Every expected value is hand-computed.
module tb_alu_sweep;
  import alu_sweep_pkg::*;

  localparam int WIDTH  = 3;
  localparam int AWIDTH = 2;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [AWIDTH-1:0] a_base, b_base, c_base;
  logic [AWIDTH:0]   len;
  logic [WIDTH-1:0]  alu_out;
  logic              alu_c_out;
  logic [AWIDTH-1:0] port_a_address, port_b_address, port_c_address;
  logic [WIDTH-1:0]  port_c_data;
  logic              port_c_we;
  logic              busy, done, carry_any;
  state_t            dbg_state;
`ifdef ALU_SWEEP_CARRY_CNT_EN
  logic [AWIDTH:0]   carry_cnt;
`endif

  // harness memory and ALU model
  logic [WIDTH-1:0]  mem [0:(1<<AWIDTH)-1];
  logic              ld_en;
  logic [AWIDTH-1:0] ld_addr;
  logic [WIDTH-1:0]  ld_data;
  int                wr_cnt;
  logic [WIDTH:0]    sum;

  int errors;
  int checks;
  int w0;
  int bcnt;

  alu_sweep #(.WIDTH(WIDTH), .AWIDTH(AWIDTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .a_base         (a_base),
    .b_base         (b_base),
    .c_base         (c_base),
    .len            (len),
    .alu_out        (alu_out),
    .alu_c_out      (alu_c_out),
    .port_a_address (port_a_address),
    .port_b_address (port_b_address),
    .port_c_address (port_c_address),
    .port_c_data    (port_c_data),
    .port_c_we      (port_c_we),
    .busy           (busy),
    .done           (done),
    .carry_any      (carry_any),
`ifdef ALU_SWEEP_CARRY_CNT_EN
    .carry_cnt      (carry_cnt),
`endif
    .dbg_state      (dbg_state)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    sum       = {1'b0, mem[port_a_address]} + {1'b0, mem[port_b_address]};
    alu_out   = sum[WIDTH-1:0];
    alu_c_out = sum[WIDTH];
  end

  initial wr_cnt = 0;

  always @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (port_c_we) begin
      mem[port_c_address] <= port_c_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // advance one cycle and settle 1ns past the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input logic [AWIDTH-1:0] a, input logic [WIDTH-1:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    step();
    ld_en   = 1'b0;
  endtask

  task automatic go(input int a, input int b, input int c, input int n);
    a_base = a[AWIDTH-1:0];
    b_base = b[AWIDTH-1:0];
    c_base = c[AWIDTH-1:0];
    len    = n[AWIDTH:0];
    start  = 1'b1;
    step();
    start  = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    a_base = '0;
    b_base = '0;
    c_base = '0;
    len    = '0;
    ld_en  = 1'b0;
    ld_addr = '0;
    ld_data = '0;

    // ---- reset state
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", port_c_we, 0);
    chk("rst_carry_any", carry_any, 0);
    chk("rst_pa", port_a_address, 0);
    chk("rst_pc", port_c_address, 0);
    chk("rst_data", port_c_data, 0);
`ifdef ALU_SWEEP_CARRY_CNT_EN
    chk("rst_carry_cnt", carry_cnt, 0);
`endif
    #20 rst_n = 1'b1;
    step();

    // ---- 3 + 2 = 5, no carry
    ld(0, 3);
    ld(1, 2);
    go(0, 1, 2, 1);
    chk("t1_read_state", dbg_state, ST_READ);
    chk("t1_read_busy", busy, 1);
    chk("t1_read_pa", port_a_address, 0);
    chk("t1_read_pb", port_b_address, 1);
    chk("t1_read_we", port_c_we, 0);
    step();
    chk("t1_write_we", port_c_we, 1);
    chk("t1_write_pc", port_c_address, 2);
    chk("t1_write_data", port_c_data, 5);
    chk("t1_write_pa_stable", port_a_address, 0);
    step();
    chk("t1_done", done, 1);
    chk("t1_done_busy", busy, 0);
    chk("t1_done_we", port_c_we, 0);
    chk("t1_carry_any", carry_any, 0);
    chk("t1_mem2", mem[2], 5);
    step();
    chk("t1_idle_done", done, 0);
    chk("t1_idle_state", dbg_state, ST_IDLE);

    // ---- 6 + 5 = 11 -> 3 with carry
    ld(0, 6);
    ld(1, 5);
    go(0, 1, 2, 1);
    step();
    chk("t2_write_data", port_c_data, 3);
    step();
    chk("t2_done", done, 1);
    chk("t2_carry_any", carry_any, 1);
    chk("t2_mem2", mem[2], 3);
`ifdef ALU_SWEEP_CARRY_CNT_EN
    chk("t2_carry_cnt", carry_cnt, 1);
`endif
    step();
    chk("t2_carry_any_held", carry_any, 1);
`ifdef ALU_SWEEP_CARRY_CNT_EN
    chk("t2_carry_cnt_held", carry_cnt, 1);
`endif

    // ---- wrap-around sweep, with ignored start requests while busy
    ld(3, 1);
    ld(0, 2);
    go(3, 3, 3, 2);
    bcnt = 0;
    if (busy) bcnt++;
    chk("t3_carry_cleared", carry_any, 0);
    // these requests must be ignored
    start  = 1'b1;
    len    = 3'd1;
    a_base = 2'd1;
    c_base = 2'd1;
    step();
    if (busy) bcnt++;
    chk("t3_w0_pc", port_c_address, 3);
    chk("t3_w0_data", port_c_data, 2);
    step();
    if (busy) bcnt++;
    chk("t3_r1_pa", port_a_address, 0);
    chk("t3_r1_pb", port_b_address, 0);
    step();
    if (busy) bcnt++;
    chk("t3_w1_pc", port_c_address, 0);
    chk("t3_w1_data", port_c_data, 4);
    start = 1'b0;
    step();
    if (busy) bcnt++;
    chk("t3_done", done, 1);
    chk("t3_busy_cycles", bcnt, 4);
    chk("t3_mem3", mem[3], 2);
    chk("t3_mem0", mem[0], 4);
    chk("t3_carry_any", carry_any, 0);
    step();
    chk("t3_idle", dbg_state, ST_IDLE);

    // ---- len = 0: immediate done, no write
    w0 = wr_cnt;
    go(0, 1, 2, 0);
    chk("t4_done", done, 1);
    chk("t4_busy", busy, 0);
    chk("t4_we", port_c_we, 0);
    step();
    chk("t4_done_clear", done, 0);
    chk("t4_no_write", wr_cnt, w0);

    // ---- reset during WRITE of element 1 of a len=4 sweep
    ld(0, 1);
    ld(1, 1);
    ld(3, 7);
    go(0, 1, 2, 4);
    step();
    step();
    step();
    chk("t5_w1_we", port_c_we, 1);
    w0 = wr_cnt;
    #3 rst_n = 1'b0;
    #1;
    chk("t5_rst_we", port_c_we, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_state", dbg_state, ST_IDLE);
    chk("t5_rst_pc", port_c_address, 0);
    chk("t5_rst_data", port_c_data, 0);
    step();
    chk("t5_no_more_writes", wr_cnt, w0);
    chk("t5_mem2", mem[2], 2);
    chk("t5_mem3_untouched", mem[3], 7);
    #3 rst_n = 1'b1;
    step();

    // ---- normal sweep after the abort: 1 + 1 -> mem[3]
    go(0, 1, 3, 1);
    chk("t6_busy", busy, 1);
    step();
    chk("t6_write_data", port_c_data, 2);
    step();
    chk("t6_done", done, 1);
    chk("t6_mem3", mem[3], 2);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_sweep.md
ALU_SWEEP -- requirements
Module: alu_sweep

Interface
REQ-001 Parameter WIDTH, default 3: data word width of ram_word and ALU.
REQ-002 Parameter AWIDTH, default 2: ram_word address width; depth 2^AWIDTH.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  request a sweep; sampled only in IDLE.
REQ-006 a_base, b_base, c_base  in  AWIDTH each  first operand-A, operand-B and result addresses.
REQ-007 len  in  AWIDTH+1  element count, 0..2^AWIDTH.
REQ-008 alu_out  in  WIDTH  ALU result (ALU fixed to ADD, opcode 8'h07, word-memory sources).
REQ-009 alu_c_out  in  1  ALU carry.
REQ-010 port_a_address, port_b_address  out  AWIDTH each  ram_word read addresses.
REQ-011 port_c_address  out  AWIDTH  ram_word write address; port_c_data  out  WIDTH  write data.
REQ-012 port_c_we  out  1  write enable, active-high.
REQ-013 busy  out  1  sweep in progress; done  out  1  one-cycle completion pulse.
REQ-014 carry_any  out  1  sticky: any element of the current sweep produced carry.

Function
REQ-015 States SHALL be IDLE, READ, WRITE, DONE.
REQ-016 IDLE: start=1 at edge k latches bases and len, clears carry_any and element index i; next state READ if len!=0, else DONE.
REQ-017 READ (cycle k+2i): addresses = a_base+i, b_base+i mod 2^AWIDTH; port_c_we=0; next WRITE.
REQ-018 WRITE (cycle k+2i+1): port_c_address=c_base+i mod 2^AWIDTH, port_c_data=alu_out, port_c_we=1; carry_any |= alu_c_out; next READ if i+1<len, else DONE.
REQ-019 Read addresses SHALL remain stable through WRITE so alu_out is valid for the write.
REQ-020 DONE: done=1 for exactly one cycle, then IDLE; len=0 gives done in cycle k, no write.
REQ-021 busy SHALL be 1 in READ and WRITE, 0 in IDLE and DONE.
REQ-022 start while not IDLE SHALL be ignored; bases/len changes mid-sweep SHALL have no effect.
REQ-023 Overlapping result and operand regions SHALL have sequential semantics: element i reads memory after writes of elements 0..i-1.
REQ-024 port_c_we SHALL never be 1 outside WRITE.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, port_c_we=0, busy=0, done=0, carry_any=0, all addresses and port_c_data 0, carry_cnt 0.
REQ-026 Reset mid-sweep SHALL abort with no further writes; a write in the reset cycle is suppressed.

Configuration
REQ-027 Macro ALU_SWEEP_CARRY_CNT_EN defined: extra output carry_cnt (AWIDTH+1 bits) counts carries in the current sweep, cleared on accepted start, held after DONE.
REQ-028 Macro undefined: carry_cnt port and counter absent; all other behaviour identical.

Structure
REQ-029 Shared include file SHALL hold state encodings and ALU opcode constant ALU_OP_ADD = 8'h07.
REQ-030 Single flat module; no sub-module; board harness instantiates it between ram_word and alu.

Verification (WIDTH=3, AWIDTH=2)
REQ-031 Reset: rst_n low mid-cycle -> all outputs 0 asynchronously, no write.
REQ-032 mem[0]=3, mem[1]=2, a_base=0, b_base=1, c_base=2, len=1, start at edge k -> write mem[2]=5 in cycle k+1, done in cycle k+2, carry_any=0.
REQ-033 mem[0]=6, mem[1]=5, same bases, len=1 -> mem[2]=3, carry_any=1, carry_cnt=1 (macro on).
REQ-034 Wrap: a_base=3, b_base=3, c_base=3, len=2, mem[3]=1, mem[0]=2 -> writes mem[3]=2 then mem[0]=4, busy high 4 cycles.
REQ-035 len=0 -> done pulse in cycle k, port_c_we never 1; start during busy -> ignored, sweep completes unchanged.
REQ-036 Reset asserted during WRITE of element 1 of len=4 -> no further writes, IDLE, next start runs normally.
